// File: rtl/conv_postproc.sv
// Convolution post-processing: magnitude, saturation, border masking and
// frame position tagging, buffered in a small drop-on-full output FIFO.
module conv_postproc #(
  parameter int PIXEL_SIZE = 12,
  parameter int IN_WIDTH   = PIXEL_SIZE + 6,
  parameter int ROW_SIZE   = 640,
  parameter int NUM_ROWS   = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_WIDTH-1:0]   in_pixel,
  input  logic                  in_valid,
  input  logic                  frame_rst,
  output logic [PIXEL_SIZE-1:0] out_pixel,
  output logic                  out_sof,
  output logic                  out_eol,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow,
  output logic [7:0]            drop_count
);

  localparam int COL_W = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW    = PIXEL_SIZE + 2;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(ROW_SIZE - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(NUM_ROWS - 1);
  localparam logic [IN_WIDTH:0] PIX_MAX  = (IN_WIDTH + 1)'((2 ** PIXEL_SIZE) - 1);
  localparam logic [AW:0]       DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [EW-1:0]    mem [FIFO_DEPTH];

  logic [IN_WIDTH:0]     in_ext, mag;
  logic [PIXEL_SIZE-1:0] pix_val;
  logic                  sof_tag, eol_tag;
  logic [EW-1:0]         entry, head;
  logic                  full, pop, accept, push, drop;

  // One extra bit so the most negative input has a representable magnitude.
  assign in_ext = {in_pixel[IN_WIDTH-1], in_pixel};
  assign mag    = in_ext[IN_WIDTH] ? ('0 - in_ext) : in_ext;

  always_comb begin
    pix_val = '0;
    if (row >= ROW_W'(2) && col >= COL_W'(2)) begin
      if (mag > PIX_MAX) pix_val = '1;
      else               pix_val = mag[PIXEL_SIZE-1:0];
    end
  end

  assign sof_tag = (row == '0) && (col == '0);
  assign eol_tag = (col == COL_LAST);
  assign entry   = {sof_tag, eol_tag, pix_val};

  assign out_valid = (count != '0);
  assign full      = (count == DEPTH_C);
  assign pop       = out_valid && out_ready;
  assign accept    = in_valid && !frame_rst;
  // A pop in the same cycle frees the slot the incoming pixel needs.
  assign push      = accept && (!full || pop);
  assign drop      = accept && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (frame_rst) begin
      col        <= '0;
      row        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (in_valid) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  // Storage is not reset; gating by out_valid keeps the head at 0 when empty.
  assign head      = mem[rd_ptr];
  assign out_pixel = out_valid ? head[PIXEL_SIZE-1:0] : '0;
  assign out_sof   = out_valid && head[EW-1];
  assign out_eol   = out_valid && head[EW-2];

endmodule
